// File: rtl/ysyx_220053_mem_responder_if.sv
// ysyx_220053_mem_responder_if: valid/ready request and response channels between a requester and the memory responder
interface ysyx_220053_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_220053_mem_responder.sv
// ysyx_220053_mem_responder: single-outstanding byte-masked 64-bit memory with configurable latency
// Define SRAM_RAND_DELAY_EN to add 0-3 LFSR-chosen extra busy cycles per request.
module ysyx_220053_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input logic clk,
    input logic rst,
    ysyx_220053_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      state, state_nx;
    logic [4:0]  cnt, load;
    logic        wen, err, accept, access, in_range;
    logic [63:0] addr, wdata, rdata, off;
    logic [7:0]  wmask;
    logic [AW-1:0] idx;
    logic [63:0] mem [DEPTH];
`ifdef SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign load = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
    assign load = 5'(LATENCY - 1);
`endif
    // Addresses below BASE must not wrap into range, hence the explicit compare.
    assign off      = addr - BASE;
    assign in_range = (addr >= BASE) && ((off >> 3) < 64'(DEPTH));
    assign idx      = off[AW+2:3];
    assign accept   = bus.req_valid && state == IDLE;
    assign access   = state == BUSY && cnt == 5'd0;
    always_comb begin
        bus.req_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
        state_nx      = accept ? BUSY
                      : access ? RESP
                      : (state == RESP && bus.rsp_ready) ? IDLE : state;
    end
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wen   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            wmask <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wen   <= bus.req_wen;
                addr  <= bus.req_addr;
                wdata <= bus.req_wdata;
                wmask <= bus.req_wmask;
                cnt   <= load;
            end else if (state == BUSY && cnt != 5'd0) begin
                cnt <= cnt - 5'd1;
            end
            if (access) begin
                rdata <= (in_range && !wen) ? mem[idx] : '0;
                err   <= !in_range;
            end
        end
    end
    // Array is deliberately unreset; a reset mid-transaction leaves state IDLE so access never fires.
    always_ff @(posedge clk) begin
        if (access && in_range && wen)
            for (int k = 0; k < 8; k++)
                if (wmask[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
    end
endmodule

// File: tb/tb_ysyx_220053_mem_responder.sv
// tb_ysyx_220053_mem_responder: vector table plus scoreboard checks of the memory responder
module tb_ysyx_220053_mem_responder;
    localparam int LATENCY = 2;
    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        logic        err;
        int          bp;
    } vec_t;
    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int last_gap;
    exp_t sb[$];
    vec_t vecs[15];
    int gaps1[32];
    int gaps2[32];
    ysyx_220053_mem_responder_if bus();
    ysyx_220053_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(LATENCY)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    endtask
    // Called at a negedge with the responder idle; returns at a negedge after the response handshake.
    task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic [63:0] rdata, input logic err, input int bp);
        exp_t e;
        logic [63:0] held;
        int n;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.rsp_ready = (bp == 0);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        sb.push_back('{rdata: rdata, err: err});
        // Scramble requester inputs: only the accept-edge values may matter.
        bus.req_valid = 1'b0;
        bus.req_wen   = ~wen;
        bus.req_addr  = addr ^ 64'h8;
        bus.req_wdata = ~wdata;
        bus.req_wmask = ~wmask;
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        last_gap = n;
        if (!bus.rsp_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles", n);
            void'(sb.pop_front());
            return;
        end
`ifdef SRAM_RAND_DELAY_EN
        chk("gap_range", 64'(n >= LATENCY && n <= LATENCY + 3), 64'd1);
`else
        chk("gap_exact", 64'(n), 64'(LATENCY));
`endif
        held = bus.rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_hold", {61'd0, bus.rsp_valid, bus.req_ready, bus.rsp_rdata == held}, 64'b101);
        end
        bus.rsp_ready = 1'b1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got response with nothing expected");
        end else begin
            e = sb.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
        @(negedge clk);
        chk("post_handshake", {62'd0, bus.rsp_valid, bus.req_ready}, 64'b01);
        bus.rsp_ready = 1'b0;
    endtask
    task automatic gap_run(output int gaps[32]);
        for (int i = 0; i < 32; i++) begin
            txn(1'b0, (i % 2) ? 64'h8000_0020 : 64'h8000_0010, 64'd0, 8'h00,
                (i % 2) ? 64'h5555_6666_7777_8888 : 64'hAAAA_BBBB_5566_7788, 1'b0, 0);
            gaps[i] = last_gap;
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0]  = '{1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0, 0};
        vecs[1]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0, 0};
        vecs[2]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0, 0};
        vecs[3]  = '{1'b1, 64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 64'd0, 1'b0, 0};
        vecs[4]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 0};
        vecs[5]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 5};
        vecs[6]  = '{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1, 0};
        vecs[7]  = '{1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1, 0};
        vecs[8]  = '{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 0};
        vecs[9]  = '{1'b1, 64'h8000_0017, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0, 0};
        vecs[10] = '{1'b0, 64'h8000_0015, 64'd0, 8'h00, 64'hAAAA_BBBB_5566_7788, 1'b0, 0};
        vecs[11] = '{1'b1, 64'h8000_0020, 64'h5555_6666_7777_8888, 8'hFF, 64'd0, 1'b0, 0};
        vecs[12] = '{1'b1, 64'h8000_1FF8, 64'h0000_0000_0000_CAFE, 8'hFF, 64'd0, 1'b0, 0};
        vecs[13] = '{1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'h0000_0000_0000_CAFE, 1'b0, 2};
        vecs[14] = '{1'b0, 64'h0000_0000_0000_0010, 64'd0, 8'h00, 64'd0, 1'b1, 0};
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b0;
        do_reset();
        foreach (vecs[i])
            txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rdata, vecs[i].err, vecs[i].bp);
        // Reset one cycle after accepting a write: the write must be dropped.
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 64'h8000_0020;
        bus.req_wdata = 64'h0000_0000_0000_DEAD;
        bus.req_wmask = 8'hFF;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("midbusy_req_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("midbusy_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("midbusy_after_rst", {62'd0, bus.req_ready, bus.rsp_valid}, 64'b10);
        txn(1'b0, 64'h8000_0020, 64'd0, 8'h00, 64'h5555_6666_7777_8888, 1'b0, 0);
        // Latency sequence must repeat exactly from reset.
        do_reset();
        gap_run(gaps1);
        do_reset();
        gap_run(gaps2);
        for (int i = 0; i < 32; i++)
            chk("gap_repeat", 64'(gaps2[i]), 64'(gaps1[i]));
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
